// File: rtl/ahb_ml_acc_seq.sv
// ahb_ml_acc_seq
//   AHB-Lite slave that buffers up to DEPTH operand pairs and streams them,
//   one pair per cycle, through the shared two-operand adder datapath,
//   accumulating the adder results into a 32-bit accumulator.
//
// Ports
//   HCLK, HRESETn          : bus clock, asynchronous active-low reset
//   HSEL..HWDATA           : AHB-Lite slave inputs (word access, HADDR[7:0] decoded)
//   HREADYOUT, HRESP       : always ready, always OKAY
//   HRDATA                 : read data (mux on the registered address)
//   dp_x, dp_y             : datapath operands, driven only while running
//   dp_p                   : datapath result (combinational dp_x + dp_y)
//   irq                    : level interrupt, mirrors the DONE flag
//
// Register map: 0x00 OPX (W), 0x04 OPY (W, push), 0x08 CTRL (W: b0 START, b1 CLR),
//               0x0C STATUS (b0 BUSY, b1 DONE w1c, b2 OVF w1c, [AW+8:8] COUNT),
//               0x10 ACC (R)
module ahb_ml_acc_seq #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA,
  output logic [31:0] dp_x,
  output logic [31:0] dp_y,
  input  logic [31:0] dp_p,
  output logic        irq
);

  localparam logic [7:0] A_OPX    = 8'h00;
  localparam logic [7:0] A_OPY    = 8'h04;
  localparam logic [7:0] A_CTRL   = 8'h08;
  localparam logic [7:0] A_STATUS = 8'h0C;
  localparam logic [7:0] A_ACC    = 8'h10;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          r_dph;
  logic          r_wr;
  logic [7:0]    r_addr;
  logic [31:0]   r_xstage;
  logic [31:0]   r_acc;
  logic [AW:0]   r_count;
  logic [AW-1:0] r_idx;
  logic          r_done;
  logic          r_ovf;
  logic [31:0]   r_bx [DEPTH];
  logic [31:0]   r_by [DEPTH];

  // Only the low address byte and word accesses are meaningful here.
  logic w_unused;
  assign w_unused = ^{HSIZE, HADDR[31:8]};

  // Address phase capture; the write itself lands at the end of the data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dph  <= 1'b0;
      r_wr   <= 1'b0;
      r_addr <= 8'h00;
    end else begin
      r_dph <= HSEL & HREADY & HTRANS[1];
      if (HSEL & HREADY & HTRANS[1]) begin
        r_wr   <= HWRITE;
        r_addr <= HADDR[7:0];
      end
    end
  end

  logic w_we, w_busy, w_full, w_last;
  logic w_wr_opx, w_wr_opy, w_wr_ctrl, w_wr_status;
  logic w_clr, w_start, w_push, w_enter_done;

  assign w_we        = r_dph & r_wr;
  assign w_wr_opx    = w_we && (r_addr == A_OPX);
  assign w_wr_opy    = w_we && (r_addr == A_OPY);
  assign w_wr_ctrl   = w_we && (r_addr == A_CTRL);
  assign w_wr_status = w_we && (r_addr == A_STATUS);
  assign w_busy      = (r_state == S_RUN);
  assign w_full      = (r_count == DEPTH_C);
  assign w_last      = ({1'b0, r_idx} == (r_count - 1'b1));
  // CLR overrides START in the same write; START only honoured from IDLE.
  assign w_clr       = w_wr_ctrl & HWDATA[1];
  assign w_start     = w_wr_ctrl & HWDATA[0] & ~HWDATA[1] & (r_state == S_IDLE);
  assign w_push      = w_wr_opy & ~w_busy;
  // DONE flag and COUNT clear happen on the edge that enters DONE, so the
  // flag is visible in the DONE-state cycle itself.
  assign w_enter_done = (w_state_next == S_DONE) && (r_state != S_DONE);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    dp_x         = 32'h0;
    dp_y         = 32'h0;
    case (r_state)
      S_IDLE: if (w_start) w_state_next = (r_count != '0) ? S_RUN : S_DONE;
      S_RUN: begin
        dp_x = r_bx[r_idx];
        dp_y = r_by[r_idx];
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (w_clr) w_state_next = S_IDLE;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_xstage <= 32'h0;
      r_acc    <= 32'h0;
      r_count  <= '0;
      r_idx    <= '0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr_opx & ~w_busy) r_xstage <= HWDATA;

      if (w_clr)                 r_count <= '0;
      else if (w_enter_done)     r_count <= '0;
      else if (w_push & ~w_full) r_count <= r_count + 1'b1;

      if (w_push & w_full)                 r_ovf <= 1'b1;
      else if (w_wr_status & HWDATA[2])    r_ovf <= 1'b0;

      // Setting DONE beats a simultaneous W1C.
      if (w_clr)                           r_done <= 1'b0;
      else if (w_enter_done)               r_done <= 1'b1;
      else if (w_start)                    r_done <= 1'b0;
      else if (w_wr_status & HWDATA[1])    r_done <= 1'b0;

      if (w_clr | w_start)  r_acc <= 32'h0;
      else if (w_busy)      r_acc <= r_acc + dp_p;

      if (w_clr | w_start)  r_idx <= '0;
      else if (w_busy)      r_idx <= r_idx + 1'b1;
    end
  end

  // Operand buffer: no reset needed, entries at or above COUNT are never read.
  always_ff @(posedge HCLK) begin
    if (w_push & ~w_full) begin
      r_bx[r_count[AW-1:0]] <= r_xstage;
      r_by[r_count[AW-1:0]] <= HWDATA;
    end
  end

  always_comb begin
    HRDATA = 32'h0;
    case (r_addr)
      A_STATUS: begin
        HRDATA[0]      = w_busy;
        HRDATA[1]      = r_done;
        HRDATA[2]      = r_ovf;
        HRDATA[AW+8:8] = r_count;
      end
      A_ACC:   HRDATA = r_acc;
      default: HRDATA = 32'h0;
    endcase
  end

  assign HREADYOUT = 1'b1;
  assign HRESP     = 2'b00;
  assign irq       = r_done;

endmodule

// File: tb/tb_ahb_ml_acc_seq.sv
module tb_ahb_ml_acc_seq;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam logic [7:0] A_OPX = 8'h00, A_OPY = 8'h04, A_CTRL = 8'h08,
                         A_STATUS = 8'h0C, A_ACC = 8'h10;

  logic        HCLK = 1'b0, HRESETn = 1'b0;
  logic        HSEL = 1'b0, HREADY = 1'b1, HWRITE = 1'b0;
  logic [1:0]  HTRANS = 2'b00;
  logic [2:0]  HSIZE = 3'd2;
  logic [31:0] HADDR = 32'h0, HWDATA = 32'h0;
  logic        HREADYOUT, irq;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA, dp_x, dp_y, dp_p;

  // The shared adder datapath.
  assign dp_p = dp_x + dp_y;

  ahb_ml_acc_seq #(.DEPTH(DEPTH), .AW(AW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HADDR(HADDR),
    .HWDATA(HWDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .dp_x(dp_x), .dp_y(dp_y), .dp_p(dp_p), .irq(irq)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end else begin
      $display("check %s: got 0x%08h", nm, act);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  // Returns 1 ns after the edge that completes the data phase.
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {24'h0, a};
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    @(posedge HCLK); #1;
  endtask

  // Returns inside the data phase with HRDATA sampled.
  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {24'h0, a};
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
  endtask

  typedef struct {
    bit          is_wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
    logic        exp_irq;
    int          gap;
  } vec_t;

  vec_t vt[$];

  function automatic void addv(bit w, logic [7:0] a, logic [31:0] d,
                               logic [31:0] e, logic ei, int g);
    vec_t v;
    v.is_wr = w; v.addr = a; v.data = d; v.exp = e; v.exp_irq = ei; v.gap = g;
    vt.push_back(v);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] qx[$], qy[$];
    logic [31:0] m_x, m_acc, e, w;
    logic        m_done, m_ovf;

    // ---------------- vector table ----------------
    addv(0, A_STATUS, 0, 32'h0, 0, 0);
    addv(0, A_ACC,    0, 32'h0, 0, 0);
    addv(0, A_OPX,    0, 32'h0, 0, 0);
    addv(0, 8'h20,    0, 32'h0, 0, 0);
    // wrap-around accumulate
    addv(1, A_OPX, 32'hFFFF_FFFF, 0, 0, 0);
    addv(1, A_OPY, 32'h0, 0, 0, 0);
    addv(1, A_OPX, 32'h1, 0, 0, 0);
    addv(1, A_OPY, 32'h0, 0, 0, 0);
    addv(0, A_STATUS, 0, 32'h200, 0, 0);
    addv(1, 8'h40, 32'hFFFF, 0, 0, 0);
    addv(0, A_STATUS, 0, 32'h200, 0, 0);
    addv(1, A_CTRL, 32'h1, 0, 0, 4);
    addv(0, A_ACC,    0, 32'h0, 1, 0);
    addv(0, A_STATUS, 0, 32'h2, 1, 0);
    addv(1, A_STATUS, 32'h2, 0, 0, 0);
    addv(0, A_STATUS, 0, 32'h0, 0, 0);
    // overflow: nine pushes into eight entries
    for (int i = 1; i <= 9; i++) begin
      addv(1, A_OPX, 32'(i), 0, 0, 0);
      addv(1, A_OPY, 32'(i), 0, 0, 0);
    end
    addv(0, A_STATUS, 0, 32'h804, 0, 0);
    addv(1, A_CTRL, 32'h1, 0, 0, 10);
    addv(0, A_ACC,    0, 32'd72, 1, 0);
    addv(0, A_STATUS, 0, 32'h6, 1, 0);
    addv(1, A_STATUS, 32'h6, 0, 0, 0);
    addv(0, A_STATUS, 0, 32'h0, 0, 0);

    // ---------------- reset state ----------------
    idle(3);
    chk("rst_dp_x", dp_x, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
    chk("rst_hresp", {30'h0, HRESP}, 32'h0);
    HRESETn = 1'b1;
    idle(1);

    foreach (vt[i]) begin
      if (vt[i].is_wr) begin
        wr(vt[i].addr, vt[i].data);
      end else begin
        rd(vt[i].addr, r);
        chk($sformatf("vec%0d_rdata", i), r, vt[i].exp);
        chk($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, vt[i].exp_irq});
      end
      if (vt[i].gap > 0) idle(vt[i].gap);
    end

    // ---------------- three-pair run, cycle by cycle ----------------
    wr(A_OPX, 1); wr(A_OPY, 2); wr(A_OPX, 3); wr(A_OPY, 4); wr(A_OPX, 5); wr(A_OPY, 6);
    wr(A_CTRL, 1);
    chk("run_c1_dp_x", dp_x, 32'd1);
    chk("run_c1_dp_y", dp_y, 32'd2);
    rd(A_STATUS, r);
    chk("run_c2_status", r, 32'h301);
    chk("run_c2_dp_x", dp_x, 32'd3);
    idle(1);
    chk("run_c3_dp_x", dp_x, 32'd5);
    idle(1);
    chk("run_done_dp_x", dp_x, 32'h0);
    chk("run_done_irq", {31'h0, irq}, 32'h1);
    rd(A_ACC, r);
    chk("run_acc", r, 32'd21);
    rd(A_STATUS, r);
    chk("run_status", r, 32'h2);

    // ---------------- START with COUNT=0 ----------------
    wr(A_CTRL, 1);
    chk("empty_irq", {31'h0, irq}, 32'h1);
    chk("empty_dp_x", dp_x, 32'h0);
    rd(A_STATUS, r);
    chk("empty_status", r, 32'h2);
    rd(A_ACC, r);
    chk("empty_acc", r, 32'h0);

    // ---------------- OPY write during RUN is ignored ----------------
    wr(A_OPX, 1); wr(A_OPY, 1); wr(A_OPX, 2); wr(A_OPY, 2); wr(A_OPX, 3); wr(A_OPY, 3);
    wr(A_CTRL, 1);
    wr(A_OPY, 50);
    idle(4);
    rd(A_ACC, r);
    chk("busy_push_acc", r, 32'd12);
    rd(A_STATUS, r);
    chk("busy_push_status", r, 32'h2);

    // ---------------- CLR on the second RUN cycle ----------------
    wr(A_OPX, 1); wr(A_OPY, 10); wr(A_OPX, 2); wr(A_OPY, 20);
    wr(A_OPX, 3); wr(A_OPY, 30); wr(A_OPX, 4); wr(A_OPY, 40);
    wr(A_CTRL, 1);
    chk("clr_c1_dp_x", dp_x, 32'd1);
    wr(A_CTRL, 3);
    chk("clr_dp_x", dp_x, 32'h0);
    chk("clr_irq", {31'h0, irq}, 32'h0);
    rd(A_STATUS, r);
    chk("clr_status", r, 32'h0);
    rd(A_ACC, r);
    chk("clr_acc", r, 32'h0);
    idle(6);
    chk("clr_stays_idle_irq", {31'h0, irq}, 32'h0);

    // ---------------- reset mid-RUN ----------------
    wr(A_OPX, 5); wr(A_OPY, 6); wr(A_OPX, 7); wr(A_OPY, 8);
    wr(A_CTRL, 1);
    chk("rstrun_c1_dp_x", dp_x, 32'd5);
    #2 HRESETn = 1'b0;
    #1;
    chk("rstrun_dp_x", dp_x, 32'h0);
    chk("rstrun_dp_y", dp_y, 32'h0);
    chk("rstrun_irq", {31'h0, irq}, 32'h0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    rd(A_STATUS, r);
    chk("rstrun_status", r, 32'h0);
    rd(A_ACC, r);
    chk("rstrun_acc", r, 32'h0);
    wr(A_OPX, 7); wr(A_OPY, 8);
    wr(A_CTRL, 1);
    idle(2);
    rd(A_ACC, r);
    chk("rstrun_fresh_acc", r, 32'd15);

    // ---------------- randomized runs against a reference model ----------------
    m_x = 32'd7; m_done = 1'b1; m_ovf = 1'b0;
    for (int it = 0; it < 25; it++) begin
      int n;
      if ($urandom_range(0, 3) == 0) begin
        wr(A_CTRL, 32'h2);
        m_done = 1'b0;
        qx.delete(); qy.delete();
      end
      n = $urandom_range(0, 10);
      for (int k = 0; k < n; k++) begin
        logic [31:0] y;
        if ($urandom_range(0, 1) == 1) begin
          m_x = $urandom;
          wr(A_OPX, m_x);
        end
        y = $urandom;
        wr(A_OPY, y);
        if (qx.size() < DEPTH) begin
          qx.push_back(m_x); qy.push_back(y);
        end else begin
          m_ovf = 1'b1;
        end
      end
      e = 32'(qx.size()) << 8;
      e = e | {29'h0, m_ovf, m_done, 1'b0};
      rd(A_STATUS, r);
      chk($sformatf("rnd%0d_pre_status", it), r, e);

      wr(A_CTRL, 32'h1);
      idle(DEPTH + 3);
      m_acc = 32'h0;
      foreach (qx[j]) m_acc = m_acc + qx[j] + qy[j];
      m_done = 1'b1;
      qx.delete(); qy.delete();
      rd(A_ACC, r);
      chk($sformatf("rnd%0d_acc", it), r, m_acc);
      rd(A_STATUS, r);
      chk($sformatf("rnd%0d_status", it), r, {29'h0, m_ovf, m_done, 1'b0});

      w = $urandom & 32'h6;
      wr(A_STATUS, w);
      if (w[1]) m_done = 1'b0;
      if (w[2]) m_ovf = 1'b0;
      rd(A_STATUS, r);
      chk($sformatf("rnd%0d_w1c_status", it), r, {29'h0, m_ovf, m_done, 1'b0});
      chk($sformatf("rnd%0d_irq", it), {31'h0, irq}, {31'h0, m_done});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
